// File: rtl/byte_pair_pkg.sv
// Shared types for the byte-pair packer: FSM state, byte/halfword aliases and word assembly.
package byte_pair_pkg;

    typedef enum logic {EMPTY = 1'b0, HALF = 1'b1} pack_state_t;

    typedef logic [7:0]  byte_t;
    typedef logic [15:0] half_t;

    localparam int WORD_CNT_W = 16;

    // Order the two bytes of a pair into {hi, lo}.
    function automatic half_t pair_word(input byte_t first, input byte_t second,
                                        input logic hi_first);
        return hi_first ? {first, second} : {second, first};
    endfunction

endpackage

// File: rtl/byte_pair_packer.sv
// Streaming byte-to-halfword assembler with valid/ready on both sides.
// Optional flush of a partial word via in_last/out_last when PACKER_FLUSH_EN is defined.
module byte_pair_packer
    import byte_pair_pkg::*;
#(
    parameter logic       HI_FIRST = 1'b1,
    parameter logic [7:0] PAD_BYTE = 8'h00
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            in_byte,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [7:0]            out_hi,
    output logic [7:0]            out_lo,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WORD_CNT_W-1:0] word_count
`ifdef PACKER_FLUSH_EN
    ,
    input  logic                  in_last,
    output logic                  out_last
`endif
);

    pack_state_t state;
    byte_t       first_byte;
    logic        last_in;
    logic        accept;
    logic        take;
    logic        load;
    half_t       new_word;

`ifdef PACKER_FLUSH_EN
    assign last_in = in_last;
`else
    assign last_in = 1'b0;
`endif

    // A byte may complete a word (HALF, or a flushing byte in EMPTY) only when
    // the word register is free or being drained this cycle.
    assign in_ready = !reset && (!out_valid || out_ready || (state == EMPTY && !last_in));

    assign accept   = in_valid && in_ready;
    assign take     = out_valid && out_ready;
    assign load     = accept && (state == HALF || last_in);
    assign new_word = (state == HALF) ? pair_word(first_byte, in_byte, HI_FIRST)
                                      : pair_word(in_byte, PAD_BYTE, HI_FIRST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= EMPTY;
            first_byte <= 8'h00;
            out_hi     <= 8'h00;
            out_lo     <= 8'h00;
            out_valid  <= 1'b0;
            word_count <= '0;
        end else begin
            if (load) begin
                {out_hi, out_lo} <= new_word;
                out_valid        <= 1'b1;
                state            <= EMPTY;
            end else begin
                if (take)
                    out_valid <= 1'b0;
                if (accept) begin
                    first_byte <= in_byte;
                    state      <= HALF;
                end
            end
            if (take)
                word_count <= word_count + WORD_CNT_W'(1);
        end
    end

`ifdef PACKER_FLUSH_EN
    always_ff @(posedge clk) begin
        if (reset)
            out_last <= 1'b0;
        else if (load)
            out_last <= last_in;
    end
`endif

endmodule

// File: tb/tb_byte_pair_packer.sv
// Directed bench for byte_pair_packer: one HI_FIRST=1 and one HI_FIRST=0 instance on a shared stream.
module tb_byte_pair_packer;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  in_byte;
    logic        in_valid;
    logic        out_ready;
    logic        hi_in_ready, lo_in_ready;
    logic [7:0]  hi_out_hi, hi_out_lo, lo_out_hi, lo_out_lo;
    logic        hi_out_valid, lo_out_valid;
    logic [15:0] hi_word_count, lo_word_count;
`ifdef PACKER_FLUSH_EN
    logic        in_last;
    logic        hi_out_last, lo_out_last;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    byte_pair_packer #(.HI_FIRST(1'b1), .PAD_BYTE(8'h00)) u_hi (
        .clk(clk), .reset(reset), .in_byte(in_byte), .in_valid(in_valid),
        .in_ready(hi_in_ready), .out_hi(hi_out_hi), .out_lo(hi_out_lo),
        .out_valid(hi_out_valid), .out_ready(out_ready), .word_count(hi_word_count)
`ifdef PACKER_FLUSH_EN
        , .in_last(in_last), .out_last(hi_out_last)
`endif
    );

    byte_pair_packer #(.HI_FIRST(1'b0), .PAD_BYTE(8'h00)) u_lo (
        .clk(clk), .reset(reset), .in_byte(in_byte), .in_valid(in_valid),
        .in_ready(lo_in_ready), .out_hi(lo_out_hi), .out_lo(lo_out_lo),
        .out_valid(lo_out_valid), .out_ready(out_ready), .word_count(lo_word_count)
`ifdef PACKER_FLUSH_EN
        , .in_last(in_last), .out_last(lo_out_last)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one byte, confirm it will be accepted, then clock it in.
    task automatic put(input logic [7:0] b);
        in_byte  = b;
        in_valid = 1'b1;
        #1;
        chk("put_rdy", {31'd0, hi_in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        in_byte   = 8'h00;
        in_valid  = 1'b0;
        out_ready = 1'b1;
`ifdef PACKER_FLUSH_EN
        in_last   = 1'b0;
`endif
        step();
        step();
        chk("rst_valid", {31'd0, hi_out_valid}, 32'd0);
        chk("rst_word",  {16'd0, hi_out_hi, hi_out_lo}, 32'h0000);
        chk("rst_count", {16'd0, hi_word_count}, 32'd0);
        chk("rst_ready", {31'd0, hi_in_ready}, 32'd0);
        reset = 1'b0;
        #1;
        chk("post_rst_ready", {31'd0, hi_in_ready}, 32'd1);

        // Basic pair, both byte orders.
        put(8'hAB);
        chk("half_novalid", {31'd0, hi_out_valid}, 32'd0);
        put(8'hCD);
        chk("w1_valid", {31'd0, hi_out_valid}, 32'd1);
        chk("w1_hi",    {16'd0, hi_out_hi, hi_out_lo}, 32'hABCD);
        chk("w1_lo",    {16'd0, lo_out_hi, lo_out_lo}, 32'hCDAB);
        chk("w1_cnt0",  {16'd0, hi_word_count}, 32'd0);
        step();
        chk("w1_drop",  {31'd0, hi_out_valid}, 32'd0);
        chk("w1_keep",  {16'd0, hi_out_hi, hi_out_lo}, 32'hABCD);
        chk("w1_cnt1",  {16'd0, hi_word_count}, 32'd1);

        put(8'h12);
        put(8'h34);
        chk("w2_lo",    {16'd0, lo_out_hi, lo_out_lo}, 32'h3412);
        chk("w2_hi",    {16'd0, hi_out_hi, hi_out_lo}, 32'h1234);
        step();
        chk("w2_cnt",   {16'd0, hi_word_count}, 32'd2);

        // Backpressure: second byte blocked while the word is undrained.
        out_ready = 1'b0;
        put(8'h11);
        put(8'h22);
        put(8'h33);
        in_byte  = 8'h44;
        in_valid = 1'b1;
        #1;
        chk("bp_block", {31'd0, hi_in_ready}, 32'd0);
        step();
        step();
        chk("bp_block2", {31'd0, hi_in_ready}, 32'd0);
        chk("bp_hold",   {16'd0, hi_out_hi, hi_out_lo}, 32'h1122);
        chk("bp_hold_lo",{16'd0, lo_out_hi, lo_out_lo}, 32'h2211);
        chk("bp_valid",  {31'd0, hi_out_valid}, 32'd1);
        chk("bp_cnt",    {16'd0, hi_word_count}, 32'd2);
        out_ready = 1'b1;
        #1;
        chk("bp_release", {31'd0, hi_in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        chk("bp_stay_valid", {31'd0, hi_out_valid}, 32'd1);
        chk("bp_w2",         {16'd0, hi_out_hi, hi_out_lo}, 32'h3344);
        chk("bp_cnt3",       {16'd0, hi_word_count}, 32'd3);
        step();
        chk("bp_cnt4",       {16'd0, hi_word_count}, 32'd4);
        chk("bp_drop",       {31'd0, hi_out_valid}, 32'd0);

        // Reset while holding a partial byte discards it.
        put(8'h5A);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mr_cnt",   {16'd0, hi_word_count}, 32'd0);
        chk("mr_valid", {31'd0, hi_out_valid}, 32'd0);
        put(8'h01);
        chk("mr_half",  {31'd0, hi_out_valid}, 32'd0);
        put(8'h02);
        chk("mr_word",  {16'd0, hi_out_hi, hi_out_lo}, 32'h0102);
        chk("mr_word_lo",{16'd0, lo_out_hi, lo_out_lo}, 32'h0201);
        step();

        // Full-rate stream from a fresh reset.
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 256; i++) begin
            in_byte  = 8'(i);
            in_valid = 1'b1;
            #1;
            chk("s_rdy", {31'd0, hi_in_ready}, 32'd1);
            step();
            if (i % 2 == 1) begin
                chk("s_valid", {31'd0, hi_out_valid}, 32'd1);
                chk("s_word",  {16'd0, hi_out_hi, hi_out_lo}, {16'd0, 8'(i - 1), 8'(i)});
            end
        end
        in_valid = 1'b0;
        step();
        chk("s_cnt",    {16'd0, hi_word_count}, 32'd128);
        chk("s_cnt_lo", {16'd0, lo_word_count}, 32'd128);
        chk("s_idle",   {31'd0, hi_out_valid}, 32'd0);

`ifdef PACKER_FLUSH_EN
        in_last = 1'b1;
        put(8'h77);
        in_last = 1'b0;
        chk("fl_word",  {16'd0, hi_out_hi, hi_out_lo}, 32'h7700);
        chk("fl_word_lo",{16'd0, lo_out_hi, lo_out_lo}, 32'h0077);
        chk("fl_last",  {31'd0, hi_out_last}, 32'd1);
        chk("fl_valid", {31'd0, hi_out_valid}, 32'd1);
        chk("fl_rdy",   {31'd0, hi_in_ready}, 32'd1);
        step();
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
